// File: rtl/complex_divider_pkg.sv
// complex_pkg: shared widths, FSM state type and quotient saturation helper
// for the complex_divider block.
//   NUM_W / DEN_W / QUO_W : numerator, divisor and quotient component widths
//   MAG_W                 : |den|^2 width
//   PROD_W                : width of num * conj(den) components
//   QDIV_W                : quotient bits produced by the serial divider
package complex_pkg;

  localparam int NUM_W  = 35;
  localparam int DEN_W  = 18;
  localparam int QUO_W  = 16;
  localparam int MAG_W  = 2 * DEN_W;
  localparam int PROD_W = NUM_W + DEN_W + 1;
  localparam int QDIV_W = QUO_W + 1;
  localparam int CNT_W  = $clog2(QUO_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [QUO_W-1:0] QUO_MAX = {1'b0, {(QUO_W-1){1'b1}}};
  localparam logic [QUO_W-1:0] QUO_MIN = {1'b1, {(QUO_W-1){1'b0}}};

  // Magnitude limits of the unsigned divider result before the sign is applied.
  localparam logic [QDIV_W-1:0] NEG_LIM = {2'b01, {(QUO_W-1){1'b0}}};
  localparam logic [QDIV_W-1:0] POS_LIM = {2'b00, {(QUO_W-1){1'b1}}};

  typedef struct packed {
    logic [QUO_W-1:0] q;
    logic             sat;
  } sat_res_t;

  // Apply sign to an unsigned quotient magnitude and clip to the QUO_W range.
  // ovf flags a magnitude that did not fit the divider at all.
  function automatic sat_res_t saturate(input logic [QDIV_W-1:0] q_mag,
                                        input logic neg,
                                        input logic ovf);
    sat_res_t          r;
    logic [QDIV_W-1:0] q_neg;
    q_neg = -q_mag;
    if (neg) begin
      if (ovf || (q_mag > NEG_LIM)) begin
        r.q   = QUO_MIN;
        r.sat = 1'b1;
      end else begin
        r.q   = q_neg[QUO_W-1:0];
        r.sat = 1'b0;
      end
    end else begin
      if (ovf || (q_mag > POS_LIM)) begin
        r.q   = QUO_MAX;
        r.sat = 1'b1;
      end else begin
        r.q   = q_mag[QUO_W-1:0];
        r.sat = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/complex_divider_serial_udiv.sv
// serial_udiv: unsigned restoring divider, one quotient bit per step.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture dividend/divisor and clear the quotient
//   step      : perform one restoring step (MSB first)
//   dividend  : unsigned dividend, must be < divisor << Q_W
//   divisor   : unsigned divisor
//   quotient  : quotient including the step being taken this cycle, so the
//               owner can register the final value on the last step edge
module serial_udiv #(
  parameter int DVD_W = 54,
  parameter int DSR_W = 36,
  parameter int Q_W   = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DSR_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient
);

  logic [DVD_W-1:0] rem;
  logic [DVD_W-1:0] dsr;
  logic [Q_W-1:0]   q_acc;
  logic             fits;
  logic [DVD_W-1:0] rem_nx;

  always_comb begin
    fits     = (rem >= dsr);
    rem_nx   = fits ? (rem - dsr) : rem;
    quotient = {q_acc[Q_W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      dsr   <= '0;
      q_acc <= '0;
    end else if (load) begin
      rem   <= dividend;
      // Align divisor with the first quotient bit (weight 2^(Q_W-1)).
      dsr   <= DVD_W'(divisor) << (Q_W - 1);
      q_acc <= '0;
    end else if (step) begin
      rem   <= rem_nx;
      dsr   <= dsr >> 1;
      q_acc <= quotient;
    end
  end

endmodule

// File: rtl/complex_divider.sv
// complex_divider: sequential complex divider quot = num / den with
// truncation toward zero and per-component saturation. One operation at a
// time, fixed latency, valid/ready on both sides.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready only in IDLE)
//   num_real, num_imag    : signed NUM_W numerator
//   den_real, den_imag    : signed DEN_W divisor
//   out_valid / out_ready : result handshake (out_valid only in DONE)
//   quot_real, quot_imag  : signed QUO_W quotient, held until next result
//   div_by_zero           : divisor was 0+0j
//   saturated             : at least one component clipped
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// PROD  | products and |den|^2 formed, divider loaded, flags registered
// DIV   | QUO_W+1 restoring steps, counter QUO_W down to 0
// DONE  | result presented, waiting for out_ready
module complex_divider
  import complex_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] num_real,
  input  logic [NUM_W-1:0] num_imag,
  input  logic [DEN_W-1:0] den_real,
  input  logic [DEN_W-1:0] den_imag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QUO_W-1:0] quot_real,
  output logic [QUO_W-1:0] quot_imag,
  output logic             div_by_zero,
  output logic             saturated
);

  localparam int MUL_W = NUM_W + DEN_W;
  localparam int PAD_W = PROD_W - MAG_W - QDIV_W;

  state_t state, state_nx;

  logic signed [NUM_W-1:0] op_num_re, op_num_im;
  logic signed [DEN_W-1:0] op_den_re, op_den_im;

  logic             div_load, div_step;
  logic [CNT_W-1:0] cnt;

  logic signed [MUL_W-1:0]  nr_x, ni_x, dr_x, di_x;
  logic signed [MUL_W-1:0]  p_rr, p_ii, p_ir, p_ri;
  logic signed [PROD_W-1:0] n_re, n_im;
  logic signed [MAG_W-1:0]  dr_m, di_m, sq_re, sq_im;
  logic [MAG_W-1:0]         mag;
  logic [PROD_W-1:0]        abs_re, abs_im, ovf_lim;

  logic neg_re, neg_im, zero_den, ovf_re, ovf_im;

  logic [QDIV_W-1:0] q_re, q_im;
  sat_res_t          s_re, s_im;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = PROD;
      PROD:    state_nx = DIV;
      DIV:     if (cnt == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    div_load  = (state == PROD);
    div_step  = (state == DIV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_num_re <= '0;
      op_num_im <= '0;
      op_den_re <= '0;
      op_den_im <= '0;
    end else if (in_ready && in_valid) begin
      op_num_re <= num_real;
      op_num_im <= num_imag;
      op_den_re <= den_real;
      op_den_im <= den_imag;
    end
  end

  // n = num * conj(den), mag = |den|^2; operands sign-extended so every
  // multiply is full width.
  always_comb begin
    nr_x    = {{DEN_W{op_num_re[NUM_W-1]}}, op_num_re};
    ni_x    = {{DEN_W{op_num_im[NUM_W-1]}}, op_num_im};
    dr_x    = {{NUM_W{op_den_re[DEN_W-1]}}, op_den_re};
    di_x    = {{NUM_W{op_den_im[DEN_W-1]}}, op_den_im};
    p_rr    = nr_x * dr_x;
    p_ii    = ni_x * di_x;
    p_ir    = ni_x * dr_x;
    p_ri    = nr_x * di_x;
    n_re    = {p_rr[MUL_W-1], p_rr} + {p_ii[MUL_W-1], p_ii};
    n_im    = {p_ir[MUL_W-1], p_ir} - {p_ri[MUL_W-1], p_ri};
    dr_m    = {{DEN_W{op_den_re[DEN_W-1]}}, op_den_re};
    di_m    = {{DEN_W{op_den_im[DEN_W-1]}}, op_den_im};
    sq_re   = dr_m * dr_m;
    sq_im   = di_m * di_m;
    mag     = sq_re + sq_im;
    abs_re  = n_re[PROD_W-1] ? -n_re : n_re;
    abs_im  = n_im[PROD_W-1] ? -n_im : n_im;
    // Quotient magnitude must fit QDIV_W bits for the restoring divider.
    ovf_lim = {{PAD_W{1'b0}}, mag, {QDIV_W{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_re   <= 1'b0;
      neg_im   <= 1'b0;
      zero_den <= 1'b0;
      ovf_re   <= 1'b0;
      ovf_im   <= 1'b0;
    end else if (div_load) begin
      neg_re   <= n_re[PROD_W-1];
      neg_im   <= n_im[PROD_W-1];
      zero_den <= (mag == '0);
      ovf_re   <= (abs_re >= ovf_lim);
      ovf_im   <= (abs_im >= ovf_lim);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (div_load)        cnt <= CNT_W'(QUO_W);
    else if (div_step && cnt != '0) cnt <= cnt - 1'b1;
  end

  serial_udiv #(.DVD_W(PROD_W), .DSR_W(MAG_W), .Q_W(QDIV_W)) u_div_re (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (abs_re),
    .divisor  (mag),
    .quotient (q_re)
  );

  serial_udiv #(.DVD_W(PROD_W), .DSR_W(MAG_W), .Q_W(QDIV_W)) u_div_im (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (abs_im),
    .divisor  (mag),
    .quotient (q_im)
  );

  always_comb begin
    s_re = saturate(q_re, neg_re, ovf_re);
    s_im = saturate(q_im, neg_im, ovf_im);
  end

  // Results are written only on the final divide step and held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_real   <= '0;
      quot_imag   <= '0;
      div_by_zero <= 1'b0;
      saturated   <= 1'b0;
    end else if (div_step && cnt == '0) begin
      if (zero_den) begin
        quot_real   <= '0;
        quot_imag   <= '0;
        div_by_zero <= 1'b1;
        saturated   <= 1'b0;
      end else begin
        quot_real   <= s_re.q;
        quot_imag   <= s_im.q;
        div_by_zero <= 1'b0;
        saturated   <= s_re.sat | s_im.sat;
      end
    end
  end

endmodule

// File: tb/tb_complex_divider.sv
// Testbench for complex_divider: directed cases, backpressure, reset
// mid-operation, random multiply/divide round trips and random general ops.
module tb_complex_divider;
  import complex_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NUM_W-1:0] num_real = '0, num_imag = '0;
  logic [DEN_W-1:0] den_real = '0, den_imag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [QUO_W-1:0] quot_real, quot_imag;
  logic             div_by_zero, saturated;

  always #5 clk = ~clk;

  complex_divider dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .num_real    (num_real),
    .num_imag    (num_imag),
    .den_real    (den_real),
    .den_imag    (den_imag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot_real   (quot_real),
    .quot_imag   (quot_imag),
    .div_by_zero (div_by_zero),
    .saturated   (saturated)
  );

  typedef struct {
    logic signed [QUO_W-1:0] qr;
    logic signed [QUO_W-1:0] qi;
    bit                      dz;
    bit                      sat;
    longint                  acc;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  bit     prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input longint qr, input longint qi, input bit dz, input bit sat);
    exp_t e;
    e.qr  = qr[QUO_W-1:0];
    e.qi  = qi[QUO_W-1:0];
    e.dz  = dz;
    e.sat = sat;
    e.acc = 0;
    return e;
  endfunction

  function automatic longint clip(input longint q, inout bit s);
    longint hi, lo;
    hi = (longint'(1) << (QUO_W - 1)) - 1;
    lo = -(longint'(1) << (QUO_W - 1));
    if (q > hi) begin s = 1'b1; return hi; end
    if (q < lo) begin s = 1'b1; return lo; end
    return q;
  endfunction

  // Reference: exact complex division in 64-bit integers, truncated toward zero.
  function automatic exp_t ref_div(input longint nr, input longint ni,
                                   input longint dr, input longint di);
    longint mag, re, im, qr, qi;
    bit     s;
    mag = dr * dr + di * di;
    re  = nr * dr + ni * di;
    im  = ni * dr - nr * di;
    s   = 1'b0;
    if (mag == 0) return mk(0, 0, 1'b1, 1'b0);
    qr = clip(re / mag, s);
    qi = clip(im / mag, s);
    return mk(qr, qi, 1'b0, s);
  endfunction

  // Called aligned #1 after a rising edge; returns #1 after the accept edge.
  task automatic issue(input longint nr, input longint ni, input longint dr,
                       input longint di, input exp_t e);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      check("issue_ready_timeout", 0, 1);
      return;
    end
    num_real = nr[NUM_W-1:0];
    num_imag = ni[NUM_W-1:0];
    den_real = dr[DEN_W-1:0];
    den_imag = di[DEN_W-1:0];
    in_valid = 1'b1;
    e.acc    = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0 || !in_ready) check("idle_timeout", 0, 1);
  endtask

  // Monitor: compares every presented result against the queue head and
  // retires it on the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        if (!prev_v) check("latency", cyc - exp_q[0].acc, QUO_W + 2);
        check("quot_real", $signed(quot_real), exp_q[0].qr);
        check("quot_imag", $signed(quot_imag), exp_q[0].qi);
        check("div_by_zero", div_by_zero, exp_q[0].dz);
        check("saturated", saturated, exp_q[0].sat);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    prev_v <= out_valid;
  end

  initial begin
    longint ar, ai, br, bi, pr, pi, nr, ni;
    int     t;

    // Operands offered during reset must be ignored.
    num_real = 35'd99;
    den_real = 18'd3;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_quot_real", quot_real, 0);
    check("rst_quot_imag", quot_imag, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    check("rst_saturated", saturated, 0);
    repeat (25) @(posedge clk);
    #1;

    // Directed cases with hand-derived results.
    issue(2, 11, 2, 1, mk(3, 4, 0, 0));
    issue(7, 0, 2, 0, mk(3, 0, 0, 0));
    issue(-7, 0, 2, 0, mk(-3, 0, 0, 0));
    issue(0, 7, 0, 2, mk(3, 0, 0, 0));
    issue(100, 5, 0, 0, mk(0, 0, 1, 0));
    issue(longint'(1) << 20, 0, 1, 0, mk(32767, 0, 0, 1));
    issue(-(longint'(1) << 20), 0, 1, 0, mk(-32768, 0, 0, 1));
    wait_idle();

    // Backpressure: hold the result while new operands are offered.
    out_ready = 1'b0;
    issue(2, 11, 2, 1, mk(3, 4, 0, 0));
    t = 0;
    while (!out_valid && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("bp_out_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      num_real = 35'(i * 1000 + 5);
      den_real = 18'(i + 7);
      check("bp_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", in_ready, 1);
    check("bp_out_valid_after", out_valid, 0);
    wait_idle();

    // Reset eight cycles after accept discards the operation.
    issue(500, -300, 3, 4, ref_div(500, -300, 3, 4));
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_quot_real", quot_real, 0);
    check("midrst_quot_imag", quot_imag, 0);
    check("midrst_flags", {div_by_zero, saturated}, 0);
    repeat (25) @(posedge clk);
    #1;
    issue(7, 0, 2, 0, mk(3, 0, 0, 0));
    wait_idle();

    // Closed loop: a*b fed back with den=b must return a exactly.
    for (int k = 0; k < 200; k++) begin
      ar = longint'($signed(16'($urandom())));
      ai = longint'($signed(16'($urandom())));
      do begin
        br = longint'($signed(18'($urandom())));
        bi = longint'($signed(18'($urandom())));
      end while (br == 0 && bi == 0);
      pr = ar * br - ai * bi;
      pi = ar * bi + ai * br;
      issue(pr, pi, br, bi, mk(ar, ai, 0, 0));
    end
    wait_idle();

    // General random operands, often saturating or with a small/zero divisor.
    for (int k = 0; k < 40; k++) begin
      nr = longint'($signed(35'({$urandom(), $urandom()})));
      ni = longint'($signed(35'({$urandom(), $urandom()})));
      if (k % 3 == 0) begin
        nr = nr >>> 14;
        ni = ni >>> 14;
      end
      br = longint'($urandom_range(0, 6)) - 3;
      bi = longint'($urandom_range(0, 6)) - 3;
      if (k % 4 == 1) begin
        br = longint'($signed(18'($urandom())));
        bi = longint'($signed(18'($urandom())));
      end
      issue(nr, ni, br, bi, ref_div(nr, ni, br, bi));
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/complex_divider.md
# complex_divider

Sequential complex divider that inverts the complex multiplication path: it takes a 35-bit complex product-domain numerator and an 18-bit complex divisor and returns the 16-bit complex quotient. Quotients are truncated toward zero and saturated. It uses a valid/ready handshake on both sides and processes one operation at a time with fixed latency. Its typical use is recovering the `a` operand downstream of `complex_multiplier`, or general channel/gain equalisation.

## Interface
- NUM_W, 35, numerator component width (signed two's complement)
- DEN_W, 18, denominator component width (signed)
- QUO_W, 16, quotient component width (signed)
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept; high only in IDLE
- num_real, num_imag  input  NUM_W  numerator
- den_real, den_imag  input  DEN_W  divisor
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  downstream accepts the result
- quot_real, quot_imag  output  QUO_W  quotient
- div_by_zero  output  1  divisor was 0+0j for this result
- saturated  output  1  at least one quotient component was clipped

## Operation
- Arithmetic:
  - mag = den_real² + den_imag², unsigned, 2·DEN_W bits.
  - n_re = num_real·den_real + num_imag·den_imag, signed, NUM_W+DEN_W+1 bits.
  - n_im = num_imag·den_real − num_real·den_imag, same width.
  - quot = trunc(n / mag), rounded toward zero, computed on magnitudes with the sign restored afterwards.
- Saturation, per component:
  - Positive results clip to 2^(QUO_W−1)−1.
  - Negative results clip to −2^(QUO_W−1).
  - saturated is the OR across both components.
- Division by zero (mag == 0): quot_real = quot_imag = 0, div_by_zero = 1, saturated = 0. Latency is unchanged.
- FSM states: IDLE, PROD, DIV, DONE.
  - IDLE: in_ready=1. On in_valid → PROD, latching all four operands.
  - PROD: register mag, |n_re|, |n_im|, signs, zero flag and overflow pre-check. Overflow pre-check is |n| ≥ mag<<(QUO_W+1). Iteration counter loads QUO_W. → DIV.
  - DIV: one restoring-division step per cycle on both components in parallel. Runs QUO_W+1 steps, counter counts down to 0. On the last step, register the signed and saturated results plus flags. → DONE.
  - DONE: out_valid=1 and all outputs held stable. On out_ready → IDLE.
- in_valid while not IDLE is ignored; no operands are captured.
- Reset at any time, including mid-DIV or in DONE:
  - Next state is IDLE and any in-flight operation is discarded.
  - Reset values: out_valid=0, quot_real=quot_imag=0, div_by_zero=0, saturated=0.
  - in_ready=1 from the first cycle after rst is released. Operands presented while rst=1 are not captured.

## Timing
- Accept edge E0 (in_valid & in_ready). out_valid rises after edge E0+QUO_W+2, i.e. 18 cycles for default parameters.
- Latency is the same for every case: zero divisor, saturation and normal.
- The result handshake completes on the edge where out_valid & out_ready are both high. in_ready rises after that edge.
- Minimum issue interval is QUO_W+4 cycles (20 for defaults).
- Outputs hold their last values after leaving DONE until the next result is written. Consumers may only sample them when out_valid=1.
- Multiplier products feeding PROD are registered once; there is no combinational path from the inputs to the outputs.

## Structure
- Package complex_pkg holds:
  - width constants NUM_W, DEN_W, QUO_W;
  - derived widths MAG_W = 2·DEN_W and PROD_W = NUM_W+DEN_W+1;
  - the state enum typedef (IDLE, PROD, DIV, DONE);
  - saturation limit constants.
- Sub-module serial_udiv: unsigned restoring-division datapath.
  - Inputs: dividend, divisor, load, step. Outputs: quotient.
  - Instantiated twice, once each for real and imag.
  - The top level owns the FSM, counter, sign handling and saturation.

## Test plan
- Round trip: num=2+11j, den=2+1j → quot=3+4j, flags 0. out_valid exactly 18 cycles after the accept edge.
- Truncation and sign: num=7+0j, den=2+0j → quot=3+0j. num=−7+0j → quot=−3+0j. num=0+7j, den=0+2j → quot=3+0j.
- Zero divisor and saturation:
  - den=0+0j, num=100+5j → quot=0+0j, div_by_zero=1, latency 18.
  - num=2^20+0j, den=1+0j → quot_real=32767, saturated=1.
  - num=−2^20+0j, den=1+0j → quot_real=−32768, saturated=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with other operands. out_valid and quot stay stable, in_ready stays 0, and the new operands are not captured. Release out_ready → in_ready=1 the next cycle.
- Reset mid-operation: assert rst for 1 cycle, 8 cycles after accept. out_valid stays 0, all outputs read 0, in_ready=1 after release, and the next operation completes correctly.
- Random closed loop: 200 random 16-bit a and 18-bit b (b ≠ 0) are driven through complex_multiplier, then into complex_divider with den=b. The quotient must equal a exactly with saturated=0.
